// File: rtl/cmd_pkg.sv
// Shared types and command-field constants for the host command link.
// Imported by the receiver and by the control sequencer.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Command field decoded from cfg_data[19:18]
    localparam logic [1:0] CMD_STRT = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_XSET = 2'b11;

    function automatic logic [23:0] pack_frame(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return {b0, b1, b2};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchroniser, baud counter, bit FSM, shift register.
// Ports: clk, rst_n, rx in; byte_vld/byte_err strobes, byte_data, idle, fall out.
module uart_rx_byte
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       idle,
    output logic       fall
);

    localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);

    rx_state_t   state;
    logic        rx_m;
    logic        rx_s;
    logic        rx_q;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sh;
    logic        tick;

    assign fall = !rx_s && rx_q;
    assign tick = (cnt == '0);
    assign idle = (state == ST_IDLE);

    // Strobes are decoded from the stop-sample cycle so the parent
    // can register the frame on that same edge.
    assign byte_vld  = (state == ST_STOP) && tick && rx_s;
    assign byte_err  = (state == ST_STOP) && tick && !rx_s;
    assign byte_data = sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
            unique case (state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt   <= HALF;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt     <= FULL;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        sh      <= {rx_s, sh[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_rcv.sv
// Serial command receiver: assembles three UART bytes into cfg_data.
// Ports: clk, rst_n, rx, clr_rdy in; cfg_data, frm_rdy, frm_err out.
module cmd_rcv
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        clr_rdy,
    output logic [23:0] cfg_data,
    output logic        frm_rdy,
    output logic        frm_err
);

    localparam int GAP_CYC = GAP_BITS * BAUD_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    logic             byte_vld;
    logic [7:0]       byte_data;
    logic             byte_err;
    logic             idle;
    logic             fall;
    logic [1:0]       byte_cnt;
    logic [7:0]       shadow [2];
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_hit;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .byte_err  (byte_err),
        .idle      (idle),
        .fall      (fall)
    );

    assign gap_hit = (gap_cnt == GAP_W'(GAP_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_data  <= '0;
            frm_rdy   <= 1'b0;
            frm_err   <= 1'b0;
            byte_cnt  <= '0;
            shadow[0] <= '0;
            shadow[1] <= '0;
            gap_cnt   <= '0;
        end else begin
            frm_err <= byte_err;
            // Completion below overrides this clear on the same edge.
            if (clr_rdy) begin
                frm_rdy <= 1'b0;
            end
            if (byte_err) begin
                byte_cnt <= '0;
            end else if (byte_vld) begin
                if (byte_cnt == 2'd2) begin
                    cfg_data <= pack_frame(shadow[0], shadow[1], byte_data);
                    frm_rdy  <= 1'b1;
                    byte_cnt <= '0;
                end else begin
                    shadow[byte_cnt[0]] <= byte_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (gap_hit) begin
                byte_cnt <= '0;
            end
            // Gap timer only runs while a partial frame sits idle.
            if (fall || !idle || byte_cnt == 2'd0) begin
                gap_cnt <= '0;
            end else if (!gap_hit) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_rcv.sv
// Scoreboard bench for cmd_rcv: directed scenarios then random bytes.
// Expected frames/errors are queued at stimulus time, popped by a monitor.
module tb_cmd_rcv;
    import cmd_pkg::*;

    localparam int BD  = 16;
    localparam int GB  = 4;
    // Posedges from the pin-fall drive cycle to the result-visible cycle.
    localparam int LAT = 3 + BD / 2 + 9 * BD;

    typedef struct {
        logic [23:0] data;
        int          at;
    } frm_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        clr_rdy = 1'b0;
    logic [23:0] cfg_data;
    logic        frm_rdy;
    logic        frm_err;

    cmd_rcv #(
        .BAUD_DIV (BD),
        .GAP_BITS (GB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .clr_rdy  (clr_rdy),
        .cfg_data (cfg_data),
        .frm_rdy  (frm_rdy),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frm_t        exp_q[$];
    int          err_q[$];
    logic [7:0]  part[$];
    logic [23:0] last_frame = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 byte (160 cycles) and updates the reference model.
    // clr_off >= 0 pulses clr_rdy on that cycle offset from the start.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                             input int clr_off);
        logic [9:0]  fr;
        logic [23:0] f;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10 * BD; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (stop_ok) begin
                    part.push_back(b);
                    if (part.size() == 3) begin
                        f = {part[0], part[1], part[2]};
                        exp_q.push_back('{f, cyc + LAT});
                        last_frame = f;
                        part.delete();
                    end
                end else begin
                    err_q.push_back(cyc + LAT);
                    part.delete();
                end
            end
            rx = fr[i / BD];
            clr_rdy = (i == clr_off);
        end
        clr_rdy = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BD) begin
            @(negedge clk);
            rx = 1'b1;
            clr_rdy = 1'b0;
        end
        if (n > GB) part.delete();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        chk("clr_rdy_clears", frm_rdy, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    logic [23:0] pcfg = '0;
    logic        prdy = 1'b0;
    frm_t        me;
    int          mec;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cfg_data", cfg_data, 24'h0);
            chk("rst_frm_rdy", frm_rdy, 1'b0);
            chk("rst_frm_err", frm_err, 1'b0);
            pcfg = '0;
            prdy = 1'b0;
        end else begin
            if (cfg_data !== pcfg || (frm_rdy && !prdy)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame: unexpected %h at %0d, none required",
                             cfg_data, cyc);
                end else begin
                    me = exp_q.pop_front();
                    chk("frame_data", cfg_data, me.data);
                    chk("frame_cycle", cyc, me.at);
                    chk("frame_rdy", frm_rdy, 1'b1);
                end
            end
            if (frm_err) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frm_err: unexpected pulse at %0d, none required",
                             cyc);
                end else begin
                    mec = err_q.pop_front();
                    chk("err_cycle", cyc, mec);
                end
            end
            pcfg = cfg_data;
            prdy = frm_rdy;
        end
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         r;

        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_bits(2);

        // Basic frame and command field
        send_byte(8'h0C, 1'b1, -1);
        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h23, 1'b1, -1);
        chk("cmd_field", cfg_data[19:18], CMD_XSET);

        // Acknowledge, then clr_rdy in the completion cycle
        idle_bits(1);
        pulse_clr();
        chk("cfg_hold_after_clr", cfg_data, 24'h0C0123);
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, -1);
        send_byte(8'h56, 1'b1, LAT - 1);
        chk("set_wins_over_clr", frm_rdy, 1'b1);
        chk("cfg_after_set_wins", cfg_data, 24'h123456);

        // Framing error discards the partial frame
        idle_bits(1);
        send_byte(8'h55, 1'b1, -1);
        send_byte(8'hAA, 1'b0, -1);
        idle_bits(1);
        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        send_byte(8'h03, 1'b1, -1);

        // Short glitch must neither add a byte nor clear the count
        idle_bits(1);
        send_byte(8'h77, 1'b1, -1);
        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        send_byte(8'h88, 1'b1, -1);
        send_byte(8'h99, 1'b1, -1);
        chk("glitch_frame", cfg_data, 24'h778899);

        // Gap timeout drops a stale partial frame
        idle_bits(1);
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b1, -1);
        idle_bits(5);
        send_byte(8'h33, 1'b1, -1);
        send_byte(8'h44, 1'b1, -1);
        send_byte(8'h55, 1'b1, -1);
        chk("gap_frame", cfg_data, 24'h334455);

        // Reset in the middle of the second byte
        idle_bits(1);
        send_byte(8'h11, 1'b1, -1);
        for (int i = 0; i < 5 * BD; i++) begin
            @(negedge clk);
            rx = (i < BD) ? 1'b0 : i[4];
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        part.delete();
        repeat (5) @(negedge clk);
        rx = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_bits(1);
        send_byte(8'hA5, 1'b1, -1);
        send_byte(8'h5A, 1'b1, -1);
        send_byte(8'h0F, 1'b1, -1);
        chk("post_reset_frame", cfg_data, 24'hA55A0F);

        // Random traffic
        idle_bits(1);
        for (int n = 0; n < 48; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            if (ok && part.size() == 2 &&
                {part[0], part[1], b} == last_frame)
                b = b ^ 8'h01;
            send_byte(b, ok, -1);
            if (!ok) idle_bits(1);
            r = $urandom_range(0, 9);
            if (r == 0)
                idle_bits(6);
            else if (r < 4)
                idle_bits($urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0)
                pulse_clr();
        end

        idle_bits(4);
        chk("frames_pending", exp_q.size(), 0);
        chk("errs_pending", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
